// File: rtl/corr_pkg.sv
// Shared definitions for the correlation search controller and the correlator datapath:
// FSM state encoding, default coordinate/score widths and compare-mode constants.
package corr_pkg;

    localparam int COORD_W_DEF = 13;
    localparam int CORR_W_DEF  = 32;

    localparam bit CMP_MAX = 1'b0;
    localparam bit CMP_MIN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } corr_state_t;

endpackage

// File: rtl/corr_raster_gen.sv
// Raster-order X/Y stepper over an inclusive window; flags the final point so the
// caller never steps past X_MAX/Y_MAX.
module corr_raster_gen #(
    parameter int COORD_W = 13,
    parameter int X_MIN   = 0,
    parameter int X_MAX   = 639,
    parameter int Y_MIN   = 0,
    parameter int Y_MAX   = 479,
    parameter int X_STEP  = 1,
    parameter int Y_STEP  = 1
)(
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iInit,
    input  logic               iAdvance,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    output logic               oLast
);

    localparam logic [COORD_W:0]   LP_X_MAX  = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   LP_Y_MAX  = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0]   LP_X_STEP = (COORD_W+1)'(X_STEP);
    localparam logic [COORD_W:0]   LP_Y_STEP = (COORD_W+1)'(Y_STEP);
    localparam logic [COORD_W-1:0] LP_X_MIN  = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] LP_Y_MIN  = COORD_W'(Y_MIN);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W:0]   w_x_inc;
    logic [COORD_W:0]   w_y_inc;
    logic               w_x_ok;
    logic               w_y_ok;

    // One extra bit keeps the increment from wrapping near the top of the coordinate range.
    assign w_x_inc = {1'b0, r_x} + LP_X_STEP;
    assign w_y_inc = {1'b0, r_y} + LP_Y_STEP;
    assign w_x_ok  = (w_x_inc <= LP_X_MAX);
    assign w_y_ok  = (w_y_inc <= LP_Y_MAX);

    assign oX    = r_x;
    assign oY    = r_y;
    assign oLast = !w_x_ok && !w_y_ok;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_x <= LP_X_MIN;
            r_y <= LP_Y_MIN;
        end else if (iInit) begin
            r_x <= LP_X_MIN;
            r_y <= LP_Y_MIN;
        end else if (iAdvance) begin
            if (w_x_ok) begin
                r_x <= w_x_inc[COORD_W-1:0];
            end else begin
                r_x <= LP_X_MIN;
                if (w_y_ok) begin
                    r_y <= w_y_inc[COORD_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/corr_search_ctrl.sv
// Correlation search controller: raster-scans the window, issues one request per point,
// keeps the best score and publishes coordinate/score/point count on completion.
module corr_search_ctrl
    import corr_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int CORR_W   = CORR_W_DEF,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_STEP   = 1,
    parameter int Y_STEP   = 1,
    parameter bit MODE_MIN = CMP_MAX,
    parameter int HB_BITS  = 26,
    parameter int CNT_W    = 2*COORD_W
)(
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic               iAbort,
    output logic               oCorrReq,
    output logic [COORD_W-1:0] oX,
    output logic [COORD_W-1:0] oY,
    input  logic               iCorrValid,
    input  logic [CORR_W-1:0]  iCorr,
    output logic               oBusy,
    output logic               oDone,
    output logic [COORD_W-1:0] oXresult,
    output logic [COORD_W-1:0] oYresult,
    output logic [CORR_W-1:0]  oBestCorr,
    output logic [CNT_W-1:0]   oPoints,
    output logic               oStatusLed
);

    if (X_MIN < 0 || Y_MIN < 0 || X_MIN > X_MAX || Y_MIN > Y_MAX ||
        X_STEP < 1 || Y_STEP < 1 ||
        X_MAX >= (1 << COORD_W) || Y_MAX >= (1 << COORD_W)) begin : g_param_check
        $error("corr_search_ctrl: illegal search window parameters");
    end

    corr_state_t        r_state;
    corr_state_t        w_state_next;

    logic               w_start;
    logic               w_abort;
    logic               w_accept;
    logic               w_last;
    logic               w_better;

    logic [COORD_W-1:0] r_best_x;
    logic [COORD_W-1:0] r_best_y;
    logic [CORR_W-1:0]  r_best_corr;
    logic               r_best_valid;
    logic [COORD_W-1:0] w_new_best_x;
    logic [COORD_W-1:0] w_new_best_y;
    logic [CORR_W-1:0]  w_new_best_corr;

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               r_done;
    logic [COORD_W-1:0] r_x_res;
    logic [COORD_W-1:0] r_y_res;
    logic [CORR_W-1:0]  r_corr_res;
    logic [CNT_W-1:0]   r_points;
    logic [HB_BITS-1:0] r_hb;

    // Abort wins over both start and a result arriving in the same cycle.
    assign w_start  = iStart && !iAbort && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_abort  = iAbort && (r_state != ST_IDLE);
    assign w_accept = iCorrValid && !iAbort && (r_state == ST_WAIT);

    corr_raster_gen #(
        .COORD_W (COORD_W),
        .X_MIN   (X_MIN),
        .X_MAX   (X_MAX),
        .Y_MIN   (Y_MIN),
        .Y_MAX   (Y_MAX),
        .X_STEP  (X_STEP),
        .Y_STEP  (Y_STEP)
    ) u_raster (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .iInit    (w_start),
        .iAdvance (w_accept && !w_last),
        .oX       (oX),
        .oY       (oY),
        .oLast    (w_last)
    );

    // Strict compare: ties keep the point seen first in raster order.
    assign w_better = !r_best_valid ||
                      (MODE_MIN ? (iCorr < r_best_corr) : (iCorr > r_best_corr));

    assign w_new_best_x    = w_better ? oX    : r_best_x;
    assign w_new_best_y    = w_better ? oY    : r_best_y;
    assign w_new_best_corr = w_better ? iCorr : r_best_corr;
    assign w_cnt_inc       = r_cnt + CNT_W'(1);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        oCorrReq     = 1'b0;
        oBusy        = 1'b0;
        oStatusLed   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                oCorrReq     = 1'b1;
                oBusy        = 1'b1;
                oStatusLed   = r_hb[HB_BITS-1];
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                oBusy      = 1'b1;
                oStatusLed = r_hb[HB_BITS-1];
                if (w_accept) w_state_next = w_last ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                oStatusLed = 1'b1;
                if (w_start) w_state_next = ST_ISSUE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_abort) w_state_next = ST_IDLE;
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_corr  <= '0;
            r_best_valid <= 1'b0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_x_res      <= '0;
            r_y_res      <= '0;
            r_corr_res   <= '0;
            r_points     <= '0;
            r_hb         <= '0;
        end else if (w_abort) begin
            r_done <= 1'b0;
        end else if (w_start) begin
            r_best_valid <= 1'b0;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_hb         <= '0;
        end else begin
            if (oBusy) r_hb <= r_hb + HB_BITS'(1);
            if (w_accept) begin
                r_cnt <= w_cnt_inc;
                if (w_better) begin
                    r_best_valid <= 1'b1;
                    r_best_x     <= oX;
                    r_best_y     <= oY;
                    r_best_corr  <= iCorr;
                end
                // Results publish from the post-update best in the same edge as DONE entry.
                if (w_last) begin
                    r_x_res    <= w_new_best_x;
                    r_y_res    <= w_new_best_y;
                    r_corr_res <= w_new_best_corr;
                    r_points   <= w_cnt_inc;
                    r_done     <= 1'b1;
                end
            end
        end
    end

    assign oDone     = r_done;
    assign oXresult  = r_x_res;
    assign oYresult  = r_y_res;
    assign oBestCorr = r_corr_res;
    assign oPoints   = r_points;

endmodule
